stack_sequencer: RTL and testbench

- Sequences every access to the single-port 16-bit data/stack memory: PUSH, POP, CALL, RET, INT and RTI stack transfers, plus LDD/STD load/store requests.
- Owns the stack pointer register and splits 32-bit PC transfers into two 16-bit word accesses.
- Sits between the decode/execute control signals and the data/stack memory.
- Raises stall to the pipeline while a multi-cycle sequence is in progress.

---
 rtl/stack_pkg.sv | 38 +++
 rtl/stack_sequencer_sp_unit.sv | 45 ++++
 rtl/stack_sequencer.sv | 173 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: op codes, FSM states and
// per-op word counts / transfer direction.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_t;

  // Zero means "not a stack op" (NOP and the reserved code).
  function automatic logic [1:0] op_words(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_POP: op_words = 2'd1;
      OP_CALL, OP_RET: op_words = 2'd2;
      OP_INT, OP_RTI:  op_words = 2'd3;
      default:         op_words = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_push(input logic [2:0] op);
    op_is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic op_is_pop(input logic [2:0] op);
    op_is_pop = (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

endpackage

// File: rtl/stack_sequencer_sp_unit.sv
// Stack pointer register with inc/dec; optional overflow/underflow guard
// compiled in with STACK_GUARD_EN.
module sp_unit #(
  parameter int ADDR_W  = 11,
  parameter int SP_INIT = 2047
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec,
  input  logic              inc,
  input  logic              chk_push,
  input  logic              chk_pop,
  input  logic [1:0]        chk_n,
  output logic [ADDR_W-1:0] sp,
  output logic              guard_err
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= ADDR_W'(SP_INIT);
    end else if (dec) begin
      sp <= sp - 1'b1;
    end else if (inc) begin
      sp <= sp + 1'b1;
    end
  end

`ifdef STACK_GUARD_EN
  localparam logic [ADDR_W:0] SP_TOP = (ADDR_W+1)'(SP_INIT);
  logic [ADDR_W:0] sp_ext;
  logic [ADDR_W:0] n_ext;

  always_comb begin
    sp_ext    = {1'b0, sp};
    n_ext     = (ADDR_W+1)'(chk_n);
    guard_err = (chk_push && (sp_ext < n_ext)) ||
                (chk_pop && ((sp_ext + n_ext) > SP_TOP));
  end
`else
  logic unused_chk;
  assign unused_chk = ^{chk_push, chk_pop, chk_n};
  assign guard_err  = 1'b0;
`endif

endmodule

// File: rtl/stack_sequencer.sv
// Sequencer for the single-port data/stack memory: stack transfers
// (PUSH/POP/CALL/RET/INT/RTI) and LDD/STD. Guard option: STACK_GUARD_EN.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 32,
  parameter int ADDR_W  = 11,
  parameter int FLAG_W  = 3,
  parameter int SP_INIT = 2047
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] push_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] pop_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              pc_load,
  output logic              flags_load,
  output logic [PC_W-1:0]   pc_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              stk_err
);

  state_t            state;
  logic [1:0]        word_cnt;
  logic [2:0]        op_q;
  logic [PC_W-1:0]   pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic [DATA_W-1:0] push_q;
  logic [DATA_W-1:0] rd_w0, rd_w1;
  logic              ld_pend;

  logic              op_req, accept, ls_go, guard_err;
  logic              xfer, is_push, do_wr, do_rd, last;
  logic [2:0]        cur_op;
  logic [1:0]        cur_n, idx;
  logic [PC_W-1:0]   pc_src;
  logic [FLAG_W-1:0] flags_src;
  logic [DATA_W-1:0] push_src, wr_word;

  // The first access happens in the accept cycle, so word 0 is taken from
  // the live inputs; later words come from the operands registered at accept.
  always_comb begin
    op_req    = reset_n && op_valid && (op_words(op_code) != 2'd0);
    accept    = (state == S_IDLE) && op_req;
    ls_go     = reset_n && ls_req && !op_req && (state == S_IDLE);
    cur_op    = accept ? op_code : op_q;
    cur_n     = op_words(cur_op);
    idx       = accept ? 2'd0 : word_cnt;
    last      = (idx == cur_n - 2'd1);
    is_push   = op_is_push(cur_op);
    xfer      = (accept && !guard_err) || (state == S_WRITE) || (state == S_READ);
    do_wr     = xfer && is_push;
    do_rd     = xfer && !is_push;
    pc_src    = accept ? pc_in : pc_q;
    flags_src = accept ? flags_in : flags_q;
    push_src  = accept ? push_data : push_q;

    wr_word = '0;
    case (cur_op)
      OP_PUSH: wr_word = push_src;
      OP_CALL, OP_INT: begin
        case (idx)
          2'd0:    wr_word = pc_src[PC_W-1:DATA_W];
          2'd1:    wr_word = pc_src[DATA_W-1:0];
          default: wr_word = DATA_W'(flags_src);
        endcase
      end
      default: ;
    endcase

    mem_we    = do_wr || (ls_go && ls_we);
    mem_re    = do_rd || (ls_go && !ls_we);
    mem_addr  = do_wr ? sp : (do_rd ? sp + 1'b1 : (ls_go ? ls_addr : '0));
    mem_wdata = do_wr ? wr_word : ((ls_go && ls_we) ? ls_wdata : '0);
    ls_ack    = ls_go;

    stk_err    = accept && guard_err;
    done       = (do_wr && last) || (state == S_DRAIN) || stk_err;
    stall      = do_rd || (do_wr && !last);
    pc_load    = (state == S_DRAIN) && ((op_q == OP_RET) || (op_q == OP_RTI));
    flags_load = (state == S_DRAIN) && (op_q == OP_RTI);
    pop_data   = ((state == S_DRAIN) && (op_q == OP_POP)) ? mem_rdata : '0;
    pc_out     = pc_load ? {mem_rdata, (op_q == OP_RTI) ? rd_w1 : rd_w0} : '0;
    flags_out  = flags_load ? rd_w0[FLAG_W-1:0] : '0;
    ld_valid   = ld_pend;
    ld_data    = ld_pend ? mem_rdata : '0;
  end

  sp_unit #(
    .ADDR_W (ADDR_W),
    .SP_INIT(SP_INIT)
  ) u_sp (
    .clk      (clk),
    .reset_n  (reset_n),
    .dec      (do_wr),
    .inc      (do_rd),
    .chk_push (accept && op_is_push(op_code)),
    .chk_pop  (accept && op_is_pop(op_code)),
    .chk_n    (op_words(op_code)),
    .sp       (sp),
    .guard_err(guard_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      op_q     <= OP_NOP;
      pc_q     <= '0;
      flags_q  <= '0;
      push_q   <= '0;
      rd_w0    <= '0;
      rd_w1    <= '0;
      ld_pend  <= 1'b0;
    end else begin
      ld_pend <= ls_go && !ls_we;
      // Read k is captured while read k+1 is issued; RTI keeps flags in w0.
      if (state == S_READ) begin
        if (word_cnt == 2'd1) rd_w0 <= mem_rdata;
        else                  rd_w1 <= mem_rdata;
      end
      case (state)
        S_IDLE: begin
          if (accept && !guard_err) begin
            op_q    <= op_code;
            pc_q    <= pc_in;
            flags_q <= flags_in;
            push_q  <= push_data;
            if (last) begin
              word_cnt <= '0;
              state    <= is_push ? S_IDLE : S_DRAIN;
            end else begin
              word_cnt <= 2'd1;
              state    <= is_push ? S_WRITE : S_READ;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= last ? '0 : word_cnt + 2'd1;
          if (last) state <= S_IDLE;
        end
        S_READ: begin
          word_cnt <= last ? '0 : word_cnt + 2'd1;
          if (last) state <= S_DRAIN;
        end
        default: begin
          word_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] push_data;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        ls_req, ls_we;
  logic [10:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack, mem_re, mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [10:0] sp;
  logic        stall, done;
  logic [15:0] pop_data, ld_data;
  logic        ld_valid, pc_load, flags_load;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic        stk_err;

  int total = 0;
  int bad   = 0;
  logic finished = 1'b0;

  logic [15:0] mem [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we === 1'b1 && mem_re === 1'b1) begin
      total++;
      bad++;
      $error("FAIL port_conflict: mem_we and mem_re both high at addr=%0h", mem_addr);
    end
  end

  stack_sequencer #(
    .DATA_W (16),
    .PC_W   (32),
    .ADDR_W (11),
    .FLAG_W (3),
    .SP_INIT(2047)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .push_data (push_data),
    .pc_in     (pc_in),
    .flags_in  (flags_in),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ack    (ls_ack),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .stall     (stall),
    .done      (done),
    .pop_data  (pop_data),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .pc_load   (pc_load),
    .flags_load(flags_load),
    .pc_out    (pc_out),
    .flags_out (flags_out),
    .stk_err   (stk_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    repeat (2000) @(posedge clk);
    if (!finished) begin
      total++;
      bad++;
      $error("FAIL timeout: sequence did not complete within 2000 cycles");
      $finish;
    end
  end

  initial begin
    mem_rdata = '0;
    reset_n   = 1'b0;
    op_valid  = 1'b0;
    op_code   = 3'd0;
    push_data = '0;
    pc_in     = '0;
    flags_in  = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    cyc; cyc;
    total++;
    if (sp !== 11'd2047 || stall !== 1'b0 || done !== 1'b0 ||
        mem_we !== 1'b0 || mem_re !== 1'b0 || stk_err !== 1'b0 ||
        ls_ack !== 1'b0 || pc_load !== 1'b0 || ld_valid !== 1'b0) begin
      bad++;
      $error("FAIL reset state: sp=%0h stall=%b done=%b we=%b re=%b err=%b",
             sp, stall, done, mem_we, mem_re, stk_err);
    end
    chk("rst_sp", sp, 11'd2047);
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    reset_n = 1'b1;

    cyc;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 11'd5; ls_wdata = 16'h5A5A;
    #1;
    chk("std_ack", ls_ack, 1'b1);
    chk("std_we", mem_we, 1'b1);
    chk("std_addr", mem_addr, 11'd5);
    cyc;
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    chk("std_mem", mem[5], 16'h5A5A);

    cyc;
    op_valid = 1'b1; op_code = 3'd1; push_data = 16'hABCD;
    #1;
    chk("push_we", mem_we, 1'b1);
    chk("push_addr", mem_addr, 11'd2047);
    chk("push_wdata", mem_wdata, 16'hABCD);
    chk("push_stall", stall, 1'b0);
    chk("push_done", done, 1'b1);
    cyc;
    op_valid = 1'b0; push_data = 16'h0000;
    #1;
    chk("push_sp", sp, 11'd2046);
    chk("push_mem", mem[2047], 16'hABCD);

    op_valid = 1'b1; op_code = 3'd2;
    #1;
    chk("pop_re", mem_re, 1'b1);
    chk("pop_addr", mem_addr, 11'd2047);
    chk("pop_stall", stall, 1'b1);
    chk("pop_done0", done, 1'b0);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("pop_done", done, 1'b1);
    chk("pop_data", pop_data, 16'hABCD);
    chk("pop_sp", sp, 11'd2047);
    chk("pop_stall1", stall, 1'b0);

    cyc;
    op_valid = 1'b1; op_code = 3'd3; pc_in = 32'h0001_0020;
    #1;
    chk("call_w0", mem_wdata, 16'h0001);
    chk("call_a0", mem_addr, 11'd2047);
    chk("call_stall0", stall, 1'b1);
    cyc;
    op_valid = 1'b0; pc_in = 32'hFFFF_FFFF;
    #1;
    chk("call_w1", mem_wdata, 16'h0020);
    chk("call_a1", mem_addr, 11'd2046);
    chk("call_stall1", stall, 1'b0);
    chk("call_done", done, 1'b1);
    cyc;
    chk("call_sp", sp, 11'd2045);

    op_valid = 1'b1; op_code = 3'd4;
    #1;
    chk("ret_a0", mem_addr, 11'd2046);
    chk("ret_stall0", stall, 1'b1);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("ret_a1", mem_addr, 11'd2047);
    chk("ret_done1", done, 1'b0);
    cyc;
    chk("ret_done", done, 1'b1);
    chk("ret_pcload", pc_load, 1'b1);
    chk("ret_pc", pc_out, 32'h0001_0020);
    chk("ret_sp", sp, 11'd2047);

    cyc;
    op_valid = 1'b1; op_code = 3'd5; pc_in = 32'h0000_1234; flags_in = 3'b101;
    #1;
    chk("int_w0", mem_wdata, 16'h0000);
    cyc;
    op_valid = 1'b0; flags_in = 3'b000; pc_in = '0;
    #1;
    chk("int_w1", mem_wdata, 16'h1234);
    chk("int_stall1", stall, 1'b1);
    cyc;
    chk("int_w2", mem_wdata, 16'h0005);
    chk("int_a2", mem_addr, 11'd2045);
    chk("int_done", done, 1'b1);
    chk("int_stall2", stall, 1'b0);
    cyc;
    chk("int_sp", sp, 11'd2044);
    op_valid = 1'b1; op_code = 3'd6;
    #1;
    chk("rti_a0", mem_addr, 11'd2045);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("rti_stall1", stall, 1'b1);
    cyc;
    chk("rti_stall2", stall, 1'b1);
    cyc;
    chk("rti_done", done, 1'b1);
    chk("rti_fload", flags_load, 1'b1);
    chk("rti_flags", flags_out, 3'b101);
    chk("rti_pc", pc_out, 32'h0000_1234);
    chk("rti_sp", sp, 11'd2047);

    cyc;
    op_valid = 1'b1; op_code = 3'd3; pc_in = 32'h0000_00FF;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'd5;
    #1;
    chk("arb_ack0", ls_ack, 1'b0);
    chk("arb_w0", mem_wdata, 16'h0000);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("arb_ack1", ls_ack, 1'b0);
    chk("arb_done", done, 1'b1);
    cyc;
    chk("ldd_ack", ls_ack, 1'b1);
    chk("ldd_re", mem_re, 1'b1);
    chk("ldd_addr", mem_addr, 11'd5);
    cyc;
    op_valid = 1'b1; op_code = 3'd7;
    #1;
    chk("ldd_valid", ld_valid, 1'b1);
    chk("ldd_data", ld_data, 16'h5A5A);
    chk("rsv_ack", ls_ack, 1'b1);
    chk("rsv_stall", stall, 1'b0);
    cyc;
    op_valid = 1'b0; ls_req = 1'b0;
    #1;
    chk("rsv_ldvalid", ld_valid, 1'b1);
    chk("rsv_sp", sp, 11'd2045);

    cyc;
    op_valid = 1'b1; op_code = 3'd5; pc_in = 32'h1111_2222; flags_in = 3'b011;
    #1;
    cyc;
    op_valid = 1'b0; reset_n = 1'b0;
    #1;
    chk("mrst_sp", sp, 11'd2047);
    chk("mrst_stall", stall, 1'b0);
    chk("mrst_we", mem_we, 1'b0);
    cyc;
    reset_n = 1'b1;
    #1;
    chk("mrst_we1", mem_we, 1'b0);
    chk("mrst_done1", done, 1'b0);
    cyc;
    chk("mrst_we2", mem_we, 1'b0);
    chk("mrst_sp2", sp, 11'd2047);

    op_valid = 1'b1; op_code = 3'd2;
    #1;
`ifdef STACK_GUARD_EN
    chk("uf_err", stk_err, 1'b1);
    chk("uf_done", done, 1'b1);
    chk("uf_re", mem_re, 1'b0);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("uf_sp", sp, 11'd2047);
    chk("uf_err1", stk_err, 1'b0);
`else
    chk("wrap_err", stk_err, 1'b0);
    chk("wrap_re", mem_re, 1'b1);
    chk("wrap_addr", mem_addr, 11'd0);
    cyc;
    op_valid = 1'b0;
    #1;
    chk("wrap_sp", sp, 11'd0);
    chk("wrap_done", done, 1'b1);
`endif

    cyc;
    finished = 1'b1;
    if (bad != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", bad, total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
